// File: rtl/video_timing_ctrl.sv
// rtl/video_timing_ctrl.sv - NES video raster/sync timing sequencer with PPU frame lock
// Optional frame counter is built when VTC_FRAME_COUNTER_EN is defined.
module video_timing_ctrl #(
  parameter int H_TOTAL    = 682,
  parameter int H_ACTIVE   = 512,
  parameter int HS_START   = 556,
  parameter int HS_END     = 606,
  parameter int V_ACTIVE   = 240,
  parameter int LOCK_MISS  = 3,
  parameter int V_END_NTSC = 261,
  parameter int V_END_PAL  = 311,
  parameter int VS_NTSC    = 243,
  parameter int VS_PAL     = 270,
  parameter int OL_LEFT    = 20,
  parameter int OL_RIGHT   = 16,
  parameter int OL_TOP     = 6,
  parameter int OL_BOTTOM  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pal_video,
  input  logic        overscan,
  input  logic [8:0]  count_v,
  output logic        pix_ce,
  output logic [9:0]  h,
  output logic [9:0]  v,
  output logic        hblank,
  output logic        vblank,
  output logic        de,
  output logic        ol,
  output logic        sync_h,
  output logic        sync_v,
  output logic        locked,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam logic [9:0] H_LAST_C     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACTIVE_C   = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START_C   = 10'(HS_START);
  localparam logic [9:0] HS_END_C     = 10'(HS_END);
  localparam logic [9:0] V_ACTIVE_C   = 10'(V_ACTIVE);
  localparam logic [9:0] V_END_NTSC_C = 10'(V_END_NTSC);
  localparam logic [9:0] V_END_PAL_C  = 10'(V_END_PAL);
  localparam logic [9:0] VS_NTSC_C    = 10'(VS_NTSC);
  localparam logic [9:0] VS_PAL_C     = 10'(VS_PAL);
  localparam logic [9:0] OL_H_LO_C    = 10'(OL_LEFT);
  localparam logic [9:0] OL_H_HI_C    = 10'(H_ACTIVE - OL_RIGHT);
  localparam logic [9:0] OL_V_LO_C    = 10'(OL_TOP);
  localparam logic [9:0] OL_V_HI_C    = 10'(V_ACTIVE - OL_BOTTOM);
  localparam logic [7:0] LOCK_MISS_C  = 8'(LOCK_MISS);

  typedef enum logic [1:0] {SEARCH, LOCKED, COAST} state_t;

  state_t      state_q, state_d;
  logic [7:0]  miss_q, miss_d;
  logic [8:0]  prev_cv_q, prev_cv_d;
  logic        pix_ce_q, pix_ce_d;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic        hblank_q, hblank_d, vblank_q, vblank_d;
  logic        de_q, de_d, ol_q, ol_d;
  logic        sync_h_q, sync_h_d, sync_v_q, sync_v_d;
  logic        locked_q, locked_d, frame_start_q, frame_start_d;

  logic        sf, hend, vwrap;
  logic [9:0]  vend, vs0;

  always_comb begin
    sf    = pix_ce_q && (prev_cv_q == 9'd511) && (count_v == 9'd0);
    vend  = pal_video ? V_END_PAL_C : V_END_NTSC_C;
    vs0   = pal_video ? VS_PAL_C : VS_NTSC_C;
    hend  = (h_q == H_LAST_C);
    // >= rather than == so a PAL->NTSC switch deep in the frame still wraps
    vwrap = hend && (v_q >= vend);

    pix_ce_d      = ~pix_ce_q;
    prev_cv_d     = prev_cv_q;
    h_d           = h_q;
    v_d           = v_q;
    state_d       = state_q;
    miss_d        = miss_q;
    sync_h_d      = sync_h_q;
    sync_v_d      = sync_v_q;
    frame_start_d = 1'b0;

    if (pix_ce_q) begin
      prev_cv_d     = count_v;
      frame_start_d = sf || vwrap;
      if (sf) begin
        h_d = '0;
        v_d = '0;
      end else if (hend) begin
        h_d = '0;
        v_d = vwrap ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end

      unique case (state_q)
        SEARCH: begin
          if (sf) begin
            state_d = LOCKED;
            miss_d  = '0;
          end
        end
        LOCKED: begin
          if (sf) begin
            miss_d = '0;
          end else if (vwrap) begin
            state_d = COAST;
            miss_d  = 8'd1;
          end
        end
        COAST: begin
          if (sf) begin
            state_d = LOCKED;
            miss_d  = '0;
          end else if (vwrap) begin
            if (miss_q + 8'd1 == LOCK_MISS_C) begin
              state_d = SEARCH;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = SEARCH;
          miss_d  = '0;
        end
      endcase

      // sync_v is only re-evaluated at the start of horizontal sync
      if (h_d == HS_START_C) begin
        sync_h_d = 1'b1;
        sync_v_d = (v_d >= vs0) && (v_d < vs0 + 10'd3);
      end else if (h_d == HS_END_C) begin
        sync_h_d = 1'b0;
      end
    end

    hblank_d = (h_d >= H_ACTIVE_C);
    vblank_d = (v_d >= V_ACTIVE_C);
    ol_d     = overscan && ((h_d > OL_H_HI_C) || (h_d < OL_H_LO_C) ||
                            (v_d < OL_V_LO_C) || (v_d > OL_V_HI_C));
    de_d     = !hblank_d && !vblank_d && !ol_d;
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SEARCH;
      miss_q        <= '0;
      prev_cv_q     <= '0;
      pix_ce_q      <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      de_q          <= 1'b0;
      ol_q          <= 1'b0;
      sync_h_q      <= 1'b0;
      sync_v_q      <= 1'b0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      miss_q        <= miss_d;
      prev_cv_q     <= prev_cv_d;
      pix_ce_q      <= pix_ce_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      de_q          <= de_d;
      ol_q          <= ol_d;
      sync_h_q      <= sync_h_d;
      sync_v_q      <= sync_v_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_ce      = pix_ce_q;
  assign h           = h_q;
  assign v           = v_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign de          = de_q;
  assign ol          = ol_q;
  assign sync_h      = sync_h_q;
  assign sync_v      = sync_v_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;

`ifdef VTC_FRAME_COUNTER_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: doc/video_timing_ctrl.md
Name: video_timing_ctrl

Overview:
- Timing sequencer for the NES video output path.
- Generates the pixel clock-enable, horizontal/vertical raster counters, blanking, sync and overscan mask consumed by palette lookup and output stages.
- Phase-locks the raster to the PPU by detecting the PPU `count_v` frame wrap, with a SEARCH/LOCKED/COAST lock state machine.
- Sits between the PPU and the palette/scaler stages.

Parameters:
H_TOTAL, 682, pixels per line (h wraps at H_TOTAL-1)
H_ACTIVE, 512, active pixels per line
HS_START, 556, h value at which sync_h asserts
HS_END, 606, h value at which sync_h deasserts
V_ACTIVE, 240, active lines
LOCK_MISS, 3, consecutive missed PPU frame marks before dropping to SEARCH

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pal_video  in  1  1=PAL (312 lines), 0=NTSC (262 lines)
overscan  in  1  enable overscan mask
count_v  in  9  PPU vertical counter
pix_ce  out  1  pixel clock-enable, every 2nd clk
h  out  10  horizontal counter
v  out  10  vertical counter
hblank  out  1  h >= H_ACTIVE
vblank  out  1  v >= V_ACTIVE
de  out  1  !hblank && !vblank && !ol
ol  out  1  overscan mask active
sync_h  out  1  horizontal sync
sync_v  out  1  vertical sync
locked  out  1  state == LOCKED
frame_start  out  1  one-clk pulse when h,v go to 0,0
frame_cnt  out  16  frame counter (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all outputs 0; state=SEARCH; miss=0; prev_cv=0.
- pix_ce:
  - Toggles every clk.
  - First 1 occurs on the first clk after reset deasserts.
  - All counter, sync and lock logic advances only when pix_ce=1.
- Frame mark:
  - sf = (prev_cv==511 && count_v==0), evaluated on pix_ce.
  - prev_cv <= count_v on pix_ce.
- vend = pal_video ? 311 : 261.
- Counter advance (on pix_ce):
  - hend = (h == H_TOTAL-1).
  - If sf: h<=0, v<=0.
  - Else if hend: h<=0, and v <= (v >= vend) ? 0 : v+1.
  - Else: h<=h+1.
  - `>=` guarantees wrap when pal_video changes mid-frame: PAL→NTSC at v=300 wraps at the end of that line.
- frame_start: 1 for exactly one clk, the clk in which (h,v) become (0,0), whether via sf or natural wrap.
- Lock FSM (on pix_ce):
  - SEARCH: sf → LOCKED, miss=0.
  - LOCKED:
    - sf → stay, miss=0.
    - Natural wrap (hend && v>=vend && !sf) → COAST, miss=1.
  - COAST:
    - sf → LOCKED, miss=0.
    - Natural wrap without sf → miss+1; if miss+1 == LOCK_MISS → SEARCH, miss=0.
  - sf coincident with a natural wrap counts as sf (no miss).
  - In SEARCH, counters free-run and sf realigns them.
- Blanking: hblank, vblank, ol and de are registered from the post-update h/v, so they align with h/v, same clk.
- Overscan mask: ol = overscan && (h > H_ACTIVE-16 || h < 20 || v < 6 || v > V_ACTIVE-10).
- Sync (on pix_ce):
  - At h==HS_START: sync_h<=1; sync_v <= (v >= vs0 && v < vs0+3), where vs0 = pal_video ? 270 : 243.
  - At h==HS_END: sync_h<=0.
  - sync_v changes only at HS_START.
- Reset mid-frame: next clk all outputs 0 and state SEARCH; no frame_start is generated by reset itself.

Optional Feature:
- Macro: VTC_FRAME_COUNTER_EN.
- Defined: frame_cnt increments by 1 (mod 65536) on every frame_start; reset 0.
- Undefined: frame_cnt tied to 0, no counter logic.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, count_v held 5, NTSC → pix_ce=1 on the 1st clk after reset; h counts 0..681 then wraps; v wraps 261→0; frame_start every 682*262*2 = 357368 clk; locked=0.
- Drive count_v 511→0 on a pix_ce → next pix_ce h=0, v=0, frame_start pulse, locked=1.
- After lock, stop frame marks → first natural wrap: COAST (locked=0); third consecutive missed wrap: SEARCH; mark during COAST → LOCKED.
- NTSC v=243..245 → sync_v=1 from h=556 of line 243 until h=556 of line 246; sync_h high for h=556..605 on every line. PAL → sync_v window 270..272.
- overscan=1 → ol=1 at h=497, h=19, v=5, v=231; de=0 there; h=20, v=6 → de=1. overscan=0 → ol never 1.
- pal_video 1→0 at v=300 → v wraps to 0 after line 300 completes; with VTC_FRAME_COUNTER_EN defined, frame_cnt increments by exactly 1 at that wrap.
